dmem_responder: RTL

Data-memory responder (slave) for the core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then returns a response over a second valid/ready handshake. The block is a multi-cycle replacement for the zero-latency data memory and is the target for the future stall-capable core.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory responder
// Purpose: FSM state encoding, word/byte-enable geometry, alignment check.
// Ports: none (package).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BE_W       = 4;
  localparam int WORD_BYTES = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-addressed RAM, byte-enable synchronous write, combinational read
// Purpose: backing store for dmem_responder; contents are not reset.
// Ports:
//   clk          clock
//   we           write strobe (one word, masked by be)
//   addr[AW]     word index shared by read and write
//   be[BE_W]     byte enables, bit i covers byte i
//   wdata[32]    write data
//   rdata[32]    combinational read of addr
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [BE_W-1:0] be,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory slave with wait states and response handshake
// Purpose: accepts one load/store at a time, waits WAIT_CYCLES, performs the
// access, then holds the response until the requester takes it.
// Optional: define DMEM_RESP_PERF_EN to add saturating load/store/error counters.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready               request handshake
//   req_we, req_addr, req_wdata, req_be  request payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_err                response payload
//   perf_loads/perf_stores/perf_errors  (DMEM_RESP_PERF_EN only)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
`ifdef DMEM_RESP_PERF_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_errors
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t          state, state_n;
  logic [3:0]      cnt;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [BE_W-1:0] be_q;
  logic [31:0]     arr_rdata;
  logic            accept, access, rsp_hs, req_err, mem_we;

  // Word indices at or beyond the array are errors; no wrap-around.
  assign req_err = is_misaligned(req_addr) || (req_addr[31:2] >= 30'(DEPTH_WORDS));

  // Gated with rst_n so the requester sees no ready while reset is held.
  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_we    = access && we_q && !err_q;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    access  = 1'b0;
    rsp_hs  = 1'b0;
    unique case (state)
      IDLE: if (req_valid && req_ready) begin
        accept  = 1'b1;
        state_n = WAIT;
      end
      // The edge on which the counter reads 0 is the access edge, so the
      // response appears WAIT_CYCLES+1 edges after acceptance.
      WAIT: if (cnt == 4'd0) begin
        access  = 1'b1;
        state_n = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_hs  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      be_q      <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_addr[2 +: AW];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_rdata <= (!we_q && !err_q) ? arr_rdata : 32'd0;
        rsp_err   <= err_q;
      end else if (rsp_hs) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

`ifdef DMEM_RESP_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 32'd0;
      perf_stores <= 32'd0;
      perf_errors <= 32'd0;
    end else if (rsp_hs) begin
      if (err_q) begin
        if (perf_errors != 32'hFFFF_FFFF) perf_errors <= perf_errors + 32'd1;
      end else if (we_q) begin
        if (perf_stores != 32'hFFFF_FFFF) perf_stores <= perf_stores + 32'd1;
      end else begin
        if (perf_loads != 32'hFFFF_FFFF) perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule
